demux_n_stream: RTL and testbench
=================================

// Module: demux_n_stream
// PURPOSE
// - Streaming 1-to-2**N demultiplexer: the inverse of the N-level mux tree. It routes each input word to the
//   output port whose index equals in_sel.
// - Built as a binary tree of N registered 2-way routing levels. The root level consumes sel[N-1] and the leaf
//   level consumes sel[0], so it is MSB-first like the mux tree.
// - Sits between a single producer and 2**N independent consumers, with valid/ready on every side.
// PARAMETERS
// - N   2  select width; number of tree levels; 2**N outputs; N>=1 (elaboration $fatal otherwise)
// - W   8  data word width in bits
// PORTS
// - clk        in   1          clock, rising edge
// - rst_n      in   1          reset, asynchronous assert, active-low
// - in_valid   in   1          input word valid
// - in_ready   out  1          input word accepted when in_valid && in_ready at clk edge
// - in_data    in   W          input word
// - in_sel     in   N          destination output index, 0..2**N-1
// - out_valid  out  2**N       out_valid[j] = word pending on output j
// - out_ready  in   2**N       out_ready[j] = consumer j accepts this cycle
// - out_data   out  (2**N)*W   output j word = out_data[j*W +: W]
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-low.
// - Reset state: while rst_n=0 and after release, all node slots are empty and all data/sel registers are 0.
//   - out_valid=0, out_data=0.
//   - in_ready=0 while rst_n=0; in_ready=1 from the first cycle after release.
// - Tree: level l (0..N-1) has 2**l nodes. Node (l,i) has one slot: valid, data[W], rem_sel[N-1-l].
// - Routing bit: b = sel[N-1-l] for level 0 (taken from in_sel); for deeper levels b = MSB of the parent's
//   rem_sel. Child index = 2*i+b.
//   - Leaf node (N-1,i) drives outputs 2i and 2i+1. Only the chosen output's valid is 1; out_data holds the
//     slot data on both outputs of the pair.
// - Node accept rule: ready_up = !valid || ready_down[b_held]. Accept writes the slot. A drain without a
//   simultaneous accept clears valid.
// - Simultaneous drain and accept at the same node on the same edge: the new word replaces the slot, valid
//   stays 1, and there is no bubble.
// - Ready path is combinational through at most N levels. No combinational valid->ready loop exists.
// - Latency: a word accepted at edge k is visible on out_valid[sel] after edge k+N-1 (N register stages),
//   provided nothing blocks it.
// - Throughput: 1 word/cycle sustained when every destination out_ready=1.
// - Ordering: words to the same output leave in acceptance order. Words to different outputs may complete out
//   of order only through blocking; they never overtake inside a shared node.
// - Head-of-line blocking: a stalled output stalls only its ancestor nodes. A node holding a word for a
//   blocked output stalls new words for all outputs below that node.
// - Output stability: once out_valid[j]=1, out_valid[j] and its data hold until out_ready[j]=1 at an edge.
// - Protocol rule: the producer holds in_valid, in_data and in_sel stable until accepted. A bench assertion
//   checks this. The DUT behaviour on violation is undefined.
// - Reset mid-operation: all in-flight words are discarded immediately (asynchronous). No output handshake
//   occurs for them.
// - Width rules: no arithmetic. in_sel is always in range, since 2**N outputs cover every value.
// STRUCTURE
// - Shared package demux_pkg:
//   - function node_idx(l,i) = (1<<l)-1+i, a flat node index into packed arrays
//   - function num_nodes(N) = (1<<N)-1
// - Sub-module demux_node #(W, SW): a one-slot 2-way router.
//   - Inputs: clk, rst_n, up_valid, up_ready, up_data, up_sel[SW+1], dn_valid[2], dn_ready[2], dn_data,
//     dn_sel[SW].
//   - SW=0 at the leaf level.
// - Top: generate loop over levels and nodes instantiating demux_node and wiring parent/child by 2*i+b.
//   Output arrays are wired straight from the leaf nodes.
// TESTING (N=2, W=8 unless stated)
// 1. Reset: rst_n=0 for 3 cycles with random inputs -> out_valid=4'b0000, out_data=0, in_ready=0. After
//    release in_ready=1.
// 2. Single word: data=8'hA5, sel=2'd2 accepted at edge 0, all out_ready=1 -> after edge 1
//    out_valid=4'b0100, out_data[23:16]=8'hA5. Cleared after the next edge.
// 3. Streaming: words 8'h00..8'h0F with sel=k%4, back-to-back, all out_ready=1 -> in_ready stays 1.
//    Output k receives k, k+4, k+8, k+12 in order, one word per cycle at the tree exit.
// 4. Backpressure: out_ready[3]=0; send 8'h11 and 8'h22 to sel=3, then 8'h33 to sel=0 -> the pipe fills,
//    in_ready=0 within 3 accepted words, and nothing is lost. Release out_ready[3] -> 8'h11, 8'h22, 8'h33
//    are delivered, and 8'h33 appears only on output 0.
// 5. Async reset mid-flight: 3 words in flight, rst_n=0 between edges -> out_valid=0 immediately (no clk
//    edge). After release no stale word ever appears.
// 6. Scoreboard random: N=3, W=16, 10k words, random valid/ready at 30-90% -> per-output order and data
//    match the model, out_valid/data stability holds, no drops or duplicates.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared helpers for the streaming demultiplexer tree. Tree nodes
//            are stored level by level in flat packed arrays; node (l,i)
//            lives at flat index (1<<l)-1+i.
// Revision : 1.0  initial release
// ============================================================================
package demux_pkg;

    // Flat index of node i on tree level l (root is level 0).
    function automatic int node_idx(input int l, input int i);
        return (1 << l) - 1 + i;
    endfunction

    // Total node count of an n-level binary tree.
    function automatic int num_nodes(input int n);
        return (1 << n) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_node.sv
`default_nettype none
// ============================================================================
// Module   : demux_node
// Purpose  : One-slot registered 2-way router. The MSB of the incoming select
//            picks the downstream side; the remaining select bits travel on
//            with the word to the next level.
// Ports    : clk, rst_n              clock, async active-low reset
//            up_valid/up_ready       upstream handshake
//            up_data[W], up_sel[SW+1] upstream word and remaining select
//            dn_valid[2]/dn_ready[2] per-side downstream handshake
//            dn_data[W], dn_sel      held word and select bits below this node
//                                    (1 bit tied to 0 when SW=0, the leaf)
// Revision : 1.0  initial release
// ============================================================================
module demux_node
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           up_valid,
    output logic                           up_ready,
    input  logic [W-1:0]                   up_data,
    input  logic [SW:0]                    up_sel,
    output logic [1:0]                     dn_valid,
    input  logic [1:0]                     dn_ready,
    output logic [W-1:0]                   dn_data,
    output logic [((SW > 0) ? SW : 1)-1:0] dn_sel
);

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [SW:0]   r_sel;

    logic          w_b;
    logic          w_accept;
    logic          w_drain;

    // Routing bit of the word currently held in the slot.
    assign w_b      = r_sel[SW];

    // A slot can take a new word when empty, or when its word leaves on the
    // same edge, which gives full throughput without a bubble.
    assign up_ready = !r_valid || dn_ready[w_b];
    assign w_accept = up_valid && up_ready;
    assign w_drain  = r_valid && dn_ready[w_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= up_data;
            r_sel   <= up_sel;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign dn_valid = {r_valid && w_b, r_valid && !w_b};
    assign dn_data  = r_data;

    generate
        if (SW > 0) begin : g_sel_pass
            assign dn_sel = r_sel[SW-1:0];
        end else begin : g_sel_leaf
            assign dn_sel = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demux_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_n_stream
// Purpose  : Streaming 1-to-2**N demultiplexer built as an N-level tree of
//            registered 2-way routers. The root consumes in_sel[N-1], the
//            leaves consume in_sel[0]. Valid/ready on every port.
// Ports    : clk, rst_n              clock, async active-low reset
//            in_valid/in_ready       producer handshake
//            in_data[W], in_sel[N]   word and destination index
//            out_valid[2**N]         per-output word pending
//            out_ready[2**N]         per-output consumer ready
//            out_data[(2**N)*W]      output j word at out_data[j*W +: W]
// Revision : 1.0  initial release
// ============================================================================
module demux_n_stream
    import demux_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [N-1:0]          in_sel,
    output logic [(1<<N)-1:0]     out_valid,
    input  logic [(1<<N)-1:0]     out_ready,
    output logic [(1<<N)*W-1:0]   out_data
);

    localparam int c_num_nodes = num_nodes(N);

    generate
        if (N < 1) begin : g_bad_n
            $fatal(1, "demux_n_stream: N must be >= 1");
        end
    endgenerate

    // Flat per-node buses; node k owns dn_valid/dn_ready bits [2k+1:2k],
    // dn_data word k and an N-bit select slot k (upper bits zero-padded).
    logic [2*c_num_nodes-1:0] w_dn_valid;
    logic [2*c_num_nodes-1:0] w_dn_ready;
    logic [c_num_nodes*W-1:0] w_dn_data;
    logic [c_num_nodes*N-1:0] w_dn_sel;
    logic [c_num_nodes-1:0]   w_up_ready;
    logic                     w_unused_sel;
    logic                     r_run;

    // Holds in_ready low during reset and lifts it on the first edge after
    // release; also keeps the root from accepting anything before then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Leaf select slots and padding bits are carried but never consumed.
    assign w_unused_sel = ^w_dn_sel;

    generate
        for (genvar l = 0; l < N; l++) begin : g_lvl
            localparam int c_sw = N - 1 - l;
            localparam int c_dw = (c_sw > 0) ? c_sw : 1;

            for (genvar i = 0; i < (1 << l); i++) begin : g_node
                localparam int c_k = node_idx(l, i);

                logic          w_up_valid;
                logic [W-1:0]  w_up_data;
                logic [c_sw:0] w_up_sel;

                if (l == 0) begin : g_root
                    assign w_up_valid = in_valid && r_run;
                    assign w_up_data  = in_data;
                    assign w_up_sel   = in_sel;
                    assign in_ready   = w_up_ready[0] && r_run;
                end else begin : g_child
                    // Child 2*p+b of parent p sits on the parent's side b.
                    localparam int c_p = node_idx(l - 1, i / 2);
                    localparam int c_b = i % 2;
                    assign w_up_valid               = w_dn_valid[2*c_p + c_b];
                    assign w_up_data                = w_dn_data[c_p*W +: W];
                    assign w_up_sel                 = w_dn_sel[c_p*N +: c_sw+1];
                    assign w_dn_ready[2*c_p + c_b]  = w_up_ready[c_k];
                end

                demux_node #(
                    .W  (W),
                    .SW (c_sw)
                ) u_node (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .up_valid (w_up_valid),
                    .up_ready (w_up_ready[c_k]),
                    .up_data  (w_up_data),
                    .up_sel   (w_up_sel),
                    .dn_valid (w_dn_valid[2*c_k +: 2]),
                    .dn_ready (w_dn_ready[2*c_k +: 2]),
                    .dn_data  (w_dn_data[c_k*W +: W]),
                    .dn_sel   (w_dn_sel[c_k*N +: c_dw])
                );

                if (c_dw < N) begin : g_sel_pad
                    assign w_dn_sel[c_k*N + c_dw +: N - c_dw] = '0;
                end

                // Leaf i serves outputs 2i and 2i+1; both see the slot data,
                // only the selected side raises valid.
                if (l == N - 1) begin : g_leaf
                    assign w_dn_ready[2*c_k +: 2]     = out_ready[2*i +: 2];
                    assign out_valid[2*i +: 2]        = w_dn_valid[2*c_k +: 2];
                    assign out_data[2*i*W +: W]       = w_dn_data[c_k*W +: W];
                    assign out_data[(2*i+1)*W +: W]   = w_dn_data[c_k*W +: W];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_n_stream
// Purpose  : Self-checking bench. A small instance (N=2, W=8) takes directed
//            steps; a larger one (N=3, W=16) takes random traffic compared
//            against per-output FIFO expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux_n_stream;

    localparam int N2 = 2;
    localparam int W2 = 8;
    localparam int O2 = 1 << N2;
    localparam int N3 = 3;
    localparam int W3 = 16;
    localparam int O3 = 1 << N3;
    localparam int NUM_WORDS = 10000;
    localparam int MAX_CYC   = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst2_n;
    logic              in_valid2;
    logic              in_ready2;
    logic [W2-1:0]     in_data2;
    logic [N2-1:0]     in_sel2;
    logic [O2-1:0]     out_valid2;
    logic [O2-1:0]     out_ready2;
    logic [O2*W2-1:0]  out_data2;

    logic              rst3_n;
    logic              in_valid3;
    logic              in_ready3;
    logic [W3-1:0]     in_data3;
    logic [N3-1:0]     in_sel3;
    logic [O3-1:0]     out_valid3;
    logic [O3-1:0]     out_ready3;
    logic [O3*W3-1:0]  out_data3;

    demux_n_stream #(.N(N2), .W(W2)) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_sel    (in_sel2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2)
    );

    demux_n_stream #(.N(N3), .W(W3)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3)
    );

    int checks = 0;
    int errors = 0;

    // Output handshakes seen on the small instance, in edge order.
    int            got_port[$];
    logic [W2-1:0] got_data[$];

    // Reference model for the large instance: one FIFO per output.
    logic [W3-1:0] exp_q[O3][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are read 1 time unit later.
    task automatic settle();
        #1;
    endtask

    // Record the handshakes that the next rising edge will complete, then move
    // to the following falling edge.
    task automatic adv2();
        for (int j = 0; j < O2; j++) begin
            if (out_valid2[j] && out_ready2[j]) begin
                got_port.push_back(j);
                got_data.push_back(out_data2[j*W2 +: W2]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int            acc;
        int            sent;
        int            rcvd;
        int            cyc;
        int            vprob;
        int            rprob;
        logic [O3-1:0]    pv;
        logic [O3-1:0]    pr;
        logic [O3*W3-1:0] pd;
        logic             pin_v;
        logic             pin_acc;
        logic [W3-1:0]    pin_d;
        logic [N3-1:0]    pin_s;
        int            exp_port[3];
        int            exp_word[3];

        rst2_n = 1'b0; in_valid2 = 1'b0; in_data2 = '0; in_sel2 = '0; out_ready2 = '0;
        rst3_n = 1'b0; in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; out_ready3 = '0;
        @(negedge clk);

        // ---- Reset with random inputs ----
        for (int c = 0; c < 3; c++) begin
            in_valid2  = 1'($urandom);
            in_data2   = W2'($urandom);
            in_sel2    = N2'($urandom);
            out_ready2 = O2'($urandom);
            settle();
            check("rst_out_valid", 64'(out_valid2), 64'd0);
            check("rst_out_data", 64'(out_data2), 64'd0);
            check("rst_in_ready", 64'(in_ready2), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid2 = 1'b0; out_ready2 = '1; rst2_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        settle();
        check("release_in_ready", 64'(in_ready2), 64'd1);
        check("release_out_valid", 64'(out_valid2), 64'd0);
        adv2();

        // ---- Single word A5 to output 2 ----
        got_port.delete(); got_data.delete();
        in_valid2 = 1'b1; in_data2 = 8'hA5; in_sel2 = 2'd2;
        settle();
        check("single_accept", 64'(in_ready2), 64'd1);
        adv2();
        in_valid2 = 1'b0;
        settle();
        check("single_in_tree", 64'(out_valid2), 64'd0);
        adv2();
        settle();
        check("single_valid", 64'(out_valid2), 64'b0100);
        check("single_data", 64'(out_data2[23:16]), 64'hA5);
        adv2();
        settle();
        check("single_cleared", 64'(out_valid2), 64'd0);
        adv2();

        // ---- Back-to-back stream, word k to output k%4 ----
        // Word accepted at edge k is on the outputs between edges k+1 and k+2.
        for (int t = 0; t < 18; t++) begin
            if (t < 16) begin
                in_valid2 = 1'b1; in_data2 = W2'(t); in_sel2 = N2'(t % 4);
            end else begin
                in_valid2 = 1'b0;
            end
            settle();
            if (t < 16) check("stream_in_ready", 64'(in_ready2), 64'd1);
            if (t >= 2) begin
                check("stream_valid", 64'(out_valid2), 64'(1 << ((t - 2) % 4)));
                check("stream_data", 64'(out_data2[((t - 2) % 4)*W2 +: W2]), 64'(t - 2));
            end else begin
                check("stream_empty", 64'(out_valid2), 64'd0);
            end
            adv2();
        end
        settle();
        check("stream_drained", 64'(out_valid2), 64'd0);
        adv2();

        // ---- Backpressure on output 3 ----
        got_port.delete(); got_data.delete();
        out_ready2 = 4'b0111;
        in_valid2 = 1'b1; in_data2 = 8'h11; in_sel2 = 2'd3;
        settle();
        check("bp_accept_11", 64'(in_ready2), 64'd1);
        adv2();
        in_data2 = 8'h22;
        settle();
        check("bp_accept_22", 64'(in_ready2), 64'd1);
        adv2();
        in_data2 = 8'h33; in_sel2 = 2'd0;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("bp_stall_ready", 64'(in_ready2), 64'd0);
            check("bp_stall_valid", 64'(out_valid2), 64'b1000);
            check("bp_stall_data", 64'(out_data2[31:24]), 64'h11);
            adv2();
        end
        out_ready2 = '1;
        acc = 0;
        for (int c = 0; c < 10 && acc == 0; c++) begin
            settle();
            acc = int'(in_ready2);
            adv2();
        end
        check("bp_accept_33", 64'(acc), 64'd1);
        in_valid2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            adv2();
        end
        check("bp_count", 64'(got_port.size()), 64'd3);
        exp_port = '{3, 3, 0};
        exp_word = '{32'h11, 32'h22, 32'h33};
        for (int k = 0; k < 3; k++) begin
            check("bp_port", 64'((k < got_port.size()) ? got_port[k] : -1), 64'(exp_port[k]));
            check("bp_data", 64'((k < got_data.size()) ? got_data[k] : 8'hXX), 64'(exp_word[k]));
        end

        // ---- Asynchronous reset with three words in flight ----
        got_port.delete(); got_data.delete();
        out_ready2 = '0;
        in_valid2 = 1'b1; in_data2 = 8'h5A; in_sel2 = 2'd1;
        settle(); check("ar_accept_a", 64'(in_ready2), 64'd1); adv2();
        in_data2 = 8'h6B; in_sel2 = 2'd3;
        settle(); check("ar_accept_b", 64'(in_ready2), 64'd1); adv2();
        in_data2 = 8'h7C; in_sel2 = 2'd0;
        settle(); check("ar_accept_c", 64'(in_ready2), 64'd1); adv2();
        in_valid2 = 1'b0;
        settle();
        check("ar_inflight", 64'(out_valid2), 64'b1010);
        #1 rst2_n = 1'b0;
        #1;
        check("ar_async_valid", 64'(out_valid2), 64'd0);
        check("ar_async_data", 64'(out_data2), 64'd0);
        check("ar_async_ready", 64'(in_ready2), 64'd0);
        @(negedge clk);
        out_ready2 = '1;
        rst2_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle();
            check("ar_no_stale", 64'(out_valid2), 64'd0);
            adv2();
        end
        check("ar_no_handshake", 64'(got_port.size()), 64'd0);

        // ---- Random traffic, N=3 W=16 ----
        rst3_n = 1'b1;
        settle();
        check("rnd_reset_valid", 64'(out_valid3), 64'd0);
        @(posedge clk);
        @(negedge clk);
        sent = 0; rcvd = 0; cyc = 0; vprob = 50; rprob = 50;
        pv = '0; pr = '0; pd = '0; pin_v = 1'b0; pin_acc = 1'b0; pin_d = '0; pin_s = '0;
        while ((sent < NUM_WORDS || rcvd < sent) && cyc < MAX_CYC) begin
            if (cyc % 500 == 0) begin
                vprob = $urandom_range(30, 90);
                rprob = $urandom_range(30, 90);
            end
            if (!in_valid3 || pin_acc) begin
                if (sent < NUM_WORDS && $urandom_range(1, 100) <= vprob) begin
                    in_valid3 = 1'b1;
                    in_data3  = W3'($urandom);
                    in_sel3   = N3'($urandom);
                end else begin
                    in_valid3 = 1'b0;
                end
            end
            for (int j = 0; j < O3; j++) out_ready3[j] = ($urandom_range(1, 100) <= rprob);
            settle();
            if (pin_v && !pin_acc)
                check("rnd_producer_hold", 64'({in_valid3, in_sel3, in_data3}), 64'({1'b1, pin_s, pin_d}));
            for (int j = 0; j < O3; j++) begin
                if (pv[j] && !pr[j]) begin
                    check("rnd_hold_valid", 64'(out_valid3[j]), 64'd1);
                    check("rnd_hold_data", 64'(out_data3[j*W3 +: W3]), 64'(pd[j*W3 +: W3]));
                end
            end
            for (int j = 0; j < O3; j++) begin
                if (out_valid3[j] && out_ready3[j]) begin
                    if (exp_q[j].size() == 0) begin
                        check("rnd_unexpected_word", 64'(exp_q[j].size()), 64'd1);
                    end else begin
                        check("rnd_data", 64'(out_data3[j*W3 +: W3]), 64'(exp_q[j].pop_front()));
                        rcvd++;
                    end
                end
            end
            pin_acc = in_valid3 && in_ready3;
            if (pin_acc) begin
                exp_q[in_sel3].push_back(in_data3);
                sent++;
            end
            pin_v = in_valid3; pin_d = in_data3; pin_s = in_sel3;
            pv = out_valid3; pr = out_ready3; pd = out_data3;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid3 = 1'b0;
        out_ready3 = '1;
        check("rnd_in_time", 64'(cyc < MAX_CYC), 64'd1);
        check("rnd_sent", 64'(sent), 64'(NUM_WORDS));
        check("rnd_received", 64'(rcvd), 64'(sent));
        for (int j = 0; j < O3; j++) check("rnd_leftover", 64'(exp_q[j].size()), 64'd0);
        settle();
        check("rnd_final_empty", 64'(out_valid3), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
